// File: rtl/spi_frame_tx_if.sv
// Host-side bundle for spi_frame_tx: command-word push handshake plus the SPI pins and status.
interface spi_frame_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_valid;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          sck;
  logic          sdo;
  logic          cs_n;
  logic          busy;
  logic          frame_done;
  logic [LW-1:0] fifo_level;

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, sck, sdo, cs_n, busy, frame_done, fifo_level
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, sck, sdo, cs_n, busy, frame_done, fifo_level
  );
endinterface

// File: rtl/spi_frame_tx.sv
// SPI mode-0 master: buffers 16-bit command words in a small FIFO and shifts each
// one out MSB first inside its own cs_n low window.
module spi_frame_tx #(
  parameter int HALF_PERIOD = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input logic           clk,
  input logic           rst_n,
  spi_frame_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0]    HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state, state_d;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop;

  logic [7:0]  timer, timer_d;
  logic [4:0]  bit_cnt, bit_cnt_d;
  logic [15:0] shreg, shreg_d;
  logic        sck_r, sck_d;
  logic        cs_n_r, cs_n_d;
  logic        sdo_r, sdo_d;
  logic        fd_r, fd_d;
  logic        timer_done;

  // wr_ready looks only at the registered level, so a same-cycle pop never frees a slot early
  assign bus.wr_ready   = (level != LVL_FULL);
  assign push           = bus.wr_valid && bus.wr_ready;
  assign bus.fifo_level = level;
  assign bus.sck        = sck_r;
  assign bus.sdo        = sdo_r;
  assign bus.cs_n       = cs_n_r;
  assign bus.frame_done = fd_r;
  assign bus.busy       = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign timer_done = (timer == ((state == GAP) ? GAP_LAST : HP_LAST));

  always_comb begin
    state_d   = state;
    timer_d   = timer + 8'd1;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    sck_d     = sck_r;
    cs_n_d    = cs_n_r;
    sdo_d     = sdo_r;
    fd_d      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (level != '0) begin
          pop       = 1'b1;
          shreg_d   = mem[rd_ptr];
          sdo_d     = mem[rd_ptr][15];
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (timer_done) begin
          timer_d = '0;
          sck_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (timer_done) begin
          timer_d = '0;
          if (sck_r) begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt + 5'd1;
            // bit 0 stays on sdo through its low half and HOLD
            if (bit_cnt != 5'd15) begin
              shreg_d = {shreg[14:0], 1'b0};
              sdo_d   = shreg[14];
            end
          end else if (bit_cnt == 5'd16) begin
            state_d = HOLD;
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (timer_done) begin
          timer_d = '0;
          cs_n_d  = 1'b1;
          sdo_d   = 1'b0;
          fd_d    = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (timer_done) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      sck_r   <= 1'b0;
      cs_n_r  <= 1'b1;
      sdo_r   <= 1'b0;
      fd_r    <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_cnt <= bit_cnt_d;
      sck_r   <= sck_d;
      cs_n_r  <= cs_n_d;
      sdo_r   <= sdo_d;
      fd_r    <= fd_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_d;
  end
endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: two instances (HALF_PERIOD 2/GAP 4 and 1/1) driven
// with directed words; a negedge monitor reassembles frames and checks timing.
module tb_spi_frame_tx;
  localparam int HP0 = 2, G0 = 4, HP1 = 1, G1 = 1, DEPTH = 4;
  localparam int K_CS = 0, K_SCK = 1, K_SDO = 2, K_FD = 3, K_BUSY = 4, K_LVL = 5, K_RDY = 6, K_QEMPTY = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_frame_tx_if #(.FIFO_DEPTH(DEPTH)) if0 ();
  spi_frame_tx_if #(.FIFO_DEPTH(DEPTH)) if1 ();

  spi_frame_tx #(.HALF_PERIOD(HP0), .GAP_CYCLES(G0), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  spi_frame_tx #(.HALF_PERIOD(HP1), .GAP_CYCLES(G1), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic m_cs [2], m_sck [2], m_sdo [2], m_fd [2], m_busy [2], m_rdy [2];
  int   m_lvl [2];
  assign m_cs[0] = if0.cs_n;        assign m_cs[1] = if1.cs_n;
  assign m_sck[0] = if0.sck;        assign m_sck[1] = if1.sck;
  assign m_sdo[0] = if0.sdo;        assign m_sdo[1] = if1.sdo;
  assign m_fd[0] = if0.frame_done;  assign m_fd[1] = if1.frame_done;
  assign m_busy[0] = if0.busy;      assign m_busy[1] = if1.busy;
  assign m_rdy[0] = if0.wr_ready;   assign m_rdy[1] = if1.wr_ready;
  assign m_lvl[0] = int'(if0.fifo_level);
  assign m_lvl[1] = int'(if1.fifo_level);

  typedef struct {int inst; int kind; int val;} req_t;
  req_t        req_q [$];
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  string       kname [8] = '{"cs_n", "sck", "sdo", "frame_done", "busy", "fifo_level", "wr_ready", "sb_pending"};
  int          hp [2] = '{HP0, HP1};
  int          gp [2] = '{G0, G1};
  int          errors = 0;
  int          checks = 0;

  task automatic expect_now(input int inst, input int kind, input int val);
    req_t r;
    r.inst = inst; r.kind = kind; r.val = val;
    req_q.push_back(r);
  endtask

  function automatic int sample(input int inst, input int kind);
    case (kind)
      K_CS:     return int'(m_cs[inst]);
      K_SCK:    return int'(m_sck[inst]);
      K_SDO:    return int'(m_sdo[inst]);
      K_FD:     return int'(m_fd[inst]);
      K_BUSY:   return int'(m_busy[inst]);
      K_LVL:    return m_lvl[inst];
      K_RDY:    return int'(m_rdy[inst]);
      K_QEMPTY: return (inst == 0) ? exp0.size() : exp1.size();
      default:  return -1;
    endcase
  endfunction

  task automatic compare(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  // monitor: applies queued point checks, then rebuilds frames from the SPI pins
  initial begin : monitor
    req_t        r;
    int          cyc;
    int          low_cnt [2], rise_cnt [2], last_rise [2], start_cyc [2];
    logic [15:0] shv [2];
    logic        sck_q [2], cs_q [2], sdo_first [2], b2b [2];
    logic [15:0] want;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      low_cnt[i] = 0; rise_cnt[i] = 0; last_rise[i] = 0; start_cyc[i] = 0;
      shv[i] = '0; sck_q[i] = 1'b0; cs_q[i] = 1'b1; sdo_first[i] = 1'b0; b2b[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      while (req_q.size() > 0) begin
        r = req_q.pop_front();
        compare($sformatf("u%0d %s", r.inst, kname[r.kind]), sample(r.inst, r.kind), r.val);
      end
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          low_cnt[i] = 0; rise_cnt[i] = 0; b2b[i] = 1'b0;
        end else begin
          if (!m_cs[i]) begin
            if (cs_q[i]) begin
              if (b2b[i]) compare($sformatf("u%0d frame_period", i), cyc - start_cyc[i], 34*hp[i] + gp[i] + 1);
              start_cyc[i] = cyc; low_cnt[i] = 0; rise_cnt[i] = 0; sdo_first[i] = m_sdo[i]; b2b[i] = 1'b0;
            end
            low_cnt[i]++;
            if (m_sck[i] && !sck_q[i]) begin
              if (rise_cnt[i] > 0) compare($sformatf("u%0d sck_rise_spacing", i), cyc - last_rise[i], 2*hp[i]);
              last_rise[i] = cyc;
              shv[i] = {shv[i][14:0], m_sdo[i]};
              rise_cnt[i]++;
            end
            if (i == 1) compare("u1 sdo_constant", int'(m_sdo[1]), int'(sdo_first[1]));
          end else if (!cs_q[i]) begin
            if (i == 0) begin
              compare("u0 sb_has_entry", int'(exp0.size() > 0), 1);
              if (exp0.size() > 0) begin want = exp0.pop_front(); compare("u0 frame_data", int'(shv[0]), int'(want)); end
            end else begin
              compare("u1 sb_has_entry", int'(exp1.size() > 0), 1);
              if (exp1.size() > 0) begin want = exp1.pop_front(); compare("u1 frame_data", int'(shv[1]), int'(want)); end
            end
            compare($sformatf("u%0d cs_low_cycles", i), low_cnt[i], 34*hp[i]);
            compare($sformatf("u%0d sck_rises", i), rise_cnt[i], 16);
            compare($sformatf("u%0d frame_done_at_end", i), int'(m_fd[i]), 1);
            b2b[i] = (m_lvl[i] != 0);
          end
          if (m_fd[i]) compare($sformatf("u%0d frame_done_only_at_cs_rise", i), int'(m_cs[i] && !cs_q[i]), 1);
        end
        sck_q[i] = m_sck[i];
        cs_q[i]  = m_cs[i];
      end
    end
  end

  task automatic push_word(input int inst, input logic [15:0] d, input bit track);
    if (inst == 0) begin
      if0.wr_valid = 1'b1; if0.wr_data = d;
      if (track) exp0.push_back(d);
    end else begin
      if1.wr_valid = 1'b1; if1.wr_data = d;
      if (track) exp1.push_back(d);
    end
    @(posedge clk); #1;
    if0.wr_valid = 1'b0;
    if1.wr_valid = 1'b0;
  endtask

  task automatic wait_sb(input int inst, input int limit);
    int n;
    n = 0;
    while (((inst == 0) ? exp0.size() : exp1.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin : stim
    logic [15:0] w [6];
    int          n;
    w = '{16'h1A01, 16'h2B02, 16'h3C03, 16'h4D04, 16'h5E05, 16'h6F06};
    if0.wr_valid = 1'b0; if0.wr_data = '0;
    if1.wr_valid = 1'b0; if1.wr_data = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_now(0, K_CS, 1);  expect_now(0, K_SCK, 0); expect_now(0, K_SDO, 0);
    expect_now(0, K_FD, 0);  expect_now(0, K_BUSY, 0); expect_now(0, K_LVL, 0);
    expect_now(0, K_RDY, 1); expect_now(1, K_CS, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single frame, then busy must drop exactly when GAP ends
    push_word(0, 16'h8003, 1'b1);
    expect_now(0, K_LVL, 1); expect_now(0, K_BUSY, 1);
    wait_sb(0, 1000);
    expect_now(0, K_BUSY, 1);
    repeat (2) @(posedge clk);
    #1;
    expect_now(0, K_BUSY, 1);
    @(posedge clk); #1;
    expect_now(0, K_BUSY, 0); expect_now(0, K_CS, 1);

    // six consecutive pushes: five fit, the sixth is held until a pop frees a slot
    for (int k = 0; k < 6; k++) begin
      if0.wr_valid = 1'b1;
      if0.wr_data  = w[k];
      if (k < 5) exp0.push_back(w[k]);
      else begin expect_now(0, K_RDY, 0); expect_now(0, K_LVL, 4); end
      @(posedge clk); #1;
    end
    n = 0;
    while (!if0.wr_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    expect_now(0, K_RDY, 1); expect_now(0, K_LVL, 3);
    exp0.push_back(w[5]);
    @(posedge clk); #1;
    if0.wr_valid = 1'b0;
    expect_now(0, K_LVL, 4); expect_now(0, K_RDY, 0);
    wait_sb(0, 3000);

    // loopback words for the PWM receiver
    push_word(0, 16'h0155, 1'b1);
    push_word(0, 16'h8001, 1'b1);
    wait_sb(0, 1000);
    repeat (8) @(posedge clk);
    #1;

    // reset during bit 7 with a second word queued
    push_word(0, 16'hA5C3, 1'b0);
    push_word(0, 16'h0F0F, 1'b0);
    n = 0;
    while (if0.cs_n && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (31) @(posedge clk);
    #1;
    expect_now(0, K_SCK, 1); expect_now(0, K_CS, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    expect_now(0, K_CS, 1);  expect_now(0, K_SCK, 0); expect_now(0, K_LVL, 0);
    expect_now(0, K_FD, 0);  expect_now(0, K_BUSY, 0); expect_now(0, K_RDY, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_now(0, K_FD, 0);
    @(posedge clk); #1;
    push_word(0, 16'h3C5A, 1'b1);
    wait_sb(0, 1000);

    // fastest SCK: constant-data frames on the second instance
    push_word(1, 16'hFFFF, 1'b1);
    push_word(1, 16'h0000, 1'b1);
    wait_sb(1, 500);

    repeat (10) @(posedge clk);
    #1;
    expect_now(0, K_QEMPTY, 0);
    expect_now(1, K_QEMPTY, 0);
    expect_now(0, K_BUSY, 0);
    expect_now(1, K_BUSY, 0);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
